// File: rtl/bsg_tag_packet_tx_pkg.sv
// bsg_tag_packet_tx_pkg
// Shared types and constants for the bsg_tag packet serializer:
//   - BSG_declare_tag_packet_tx_cmd_s : packed parallel command struct
//   - state_e                         : serializer FSM states
//   - hdr_bits / max2                 : header size and sizing helpers
`ifndef BSG_TAG_PACKET_TX_PKG_SV
`define BSG_TAG_PACKET_TX_PKG_SV

`define BSG_declare_tag_packet_tx_cmd_s(lg_els, lg_width)  \
   typedef struct packed {                                 \
      logic                          cmd_reset;            \
      logic [(lg_els)-1:0]           node_id;              \
      logic                          data_not_reset;       \
      logic [(lg_width)-1:0]         len;                  \
      logic [(1<<(lg_width))-2:0]    payload;              \
   } bsg_tag_packet_tx_cmd_s

package bsg_tag_packet_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESET_ONES,
      ST_HDR,
      ST_PAYLOAD,
      ST_GAP
   } state_e;

   // start bit + data_not_reset; node id and length widths are added on top
   localparam int HDR_FIXED_BITS = 2;

   function automatic int hdr_bits(input int lg_els, input int lg_width);
      return HDR_FIXED_BITS + lg_els + lg_width;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`endif

// File: rtl/bsg_tag_packet_tx_shifter.sv
// bsg_tag_packet_tx_shifter
// Loadable LSB-first shift register with a bit down-counter.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   load_i           : load data_i / count_i (wins over shift_i)
//   shift_i          : shift right by one, shifting fill_i into the MSB
//   bit_o            : current LSB (bit to emit this cycle)
//   done_o           : the bit being emitted this cycle is the last one
module bsg_tag_packet_tx_shifter #(
   parameter int width_p       = 15,
   parameter int count_width_p = 6
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     load_i,
   input  logic [width_p-1:0]       data_i,
   input  logic [count_width_p-1:0] count_i,
   input  logic                     shift_i,
   input  logic                     fill_i,
   output logic                     bit_o,
   output logic                     done_o
);

   logic [width_p-1:0]       sh_r;
   logic [count_width_p-1:0] cnt_r;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         sh_r  <= '0;
         cnt_r <= '0;
      end else if (load_i) begin
         sh_r  <= data_i;
         cnt_r <= count_i;
      end else if (shift_i) begin
         sh_r  <= {fill_i, sh_r[width_p-1:1]};
         cnt_r <= cnt_r - 1'b1;
      end
   end

   assign bit_o  = sh_r[0];
   assign done_o = (cnt_r == count_width_p'(1));

endmodule

// File: rtl/bsg_tag_packet_tx.sv
// bsg_tag_packet_tx
// Serializes one parallel command per valid/ready handshake onto the
// tag_clk/tag_en/tag_data lines of a bsg_tag master: either a tag packet
// (start, node id, data_not_reset, len, payload; all LSB first) or a
// master-reset burst of ones. Every command is followed by an idle gap.
//   clk_i, reset_n_i     : tag clock, synchronous active-low reset
//   v_i, ready_and_o     : command handshake
//   cmd_reset_i .. payload_i : command fields
//   tag_data_o, tag_en_o : registered serial outputs
//   busy_o               : not idle
//   sent_count_o         : completed commands, wrapping
module bsg_tag_packet_tx
   import bsg_tag_packet_tx_pkg::*;
#(
   parameter int els_p         = 16,
   parameter int lg_width_p    = 4,
   parameter int reset_ones_p  = 32,
   parameter int idle_gap_p    = 4,
   parameter int count_width_p = 16,
   localparam int lg_els_lp    = $clog2(els_p)
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic                         v_i,
   output logic                         ready_and_o,
   input  logic                         cmd_reset_i,
   input  logic [lg_els_lp-1:0]         node_id_i,
   input  logic                         data_not_reset_i,
   input  logic [lg_width_p-1:0]        len_i,
   input  logic [(1<<lg_width_p)-2:0]   payload_i,
   output logic                         tag_data_o,
   output logic                         tag_en_o,
   output logic                         busy_o,
   output logic [count_width_p-1:0]     sent_count_o
);

   localparam int payload_width_lp = (1 << lg_width_p) - 1;
   localparam int hdr_bits_lp      = hdr_bits(lg_els_lp, lg_width_p);
   localparam int shift_width_lp   = max2(hdr_bits_lp, payload_width_lp);
   localparam int max_count_lp     = max2(max2(reset_ones_p, hdr_bits_lp),
                                          max2(payload_width_lp, idle_gap_p));
   localparam int ctr_width_lp     = $clog2(max_count_lp + 1);

   `BSG_declare_tag_packet_tx_cmd_s(lg_els_lp, lg_width_p);

   bsg_tag_packet_tx_cmd_s cmd_n;
   // Node id and data_not_reset go straight into the shifter at the
   // handshake, so only the fields used after the header are held.
   logic                        cmd_reset_r;
   logic [lg_width_p-1:0]       len_r;
   logic [payload_width_lp-1:0] payload_r;

   state_e state_r, state_n;

   logic                      ld, shift, fill, cap, inc, en_n, data_n;
   logic [shift_width_lp-1:0] ld_data, hdr_word;
   logic [ctr_width_lp-1:0]   ld_count;
   logic                      sh_bit, sh_done;

   assign cmd_n = '{cmd_reset:      cmd_reset_i,
                    node_id:        node_id_i,
                    data_not_reset: data_not_reset_i,
                    len:            len_i,
                    payload:        payload_i};

   // Header in transmit order starting at bit 0: start, node_id, dnr, len
   always_comb begin
      hdr_word = '0;
      hdr_word[hdr_bits_lp-1:0] = {cmd_n.len, cmd_n.data_not_reset, cmd_n.node_id, 1'b1};
   end

   bsg_tag_packet_tx_shifter #(
      .width_p       (shift_width_lp),
      .count_width_p (ctr_width_lp)
   ) shifter (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .load_i    (ld),
      .data_i    (ld_data),
      .count_i   (ld_count),
      .shift_i   (shift),
      .fill_i    (fill),
      .bit_o     (sh_bit),
      .done_o    (sh_done)
   );

   always_comb begin
      state_n  = state_r;
      ld       = 1'b0;
      ld_data  = '0;
      ld_count = '0;
      shift    = 1'b0;
      fill     = 1'b0;
      cap      = 1'b0;
      inc      = 1'b0;
      en_n     = 1'b0;
      data_n   = 1'b0;
      unique case (state_r)
         ST_IDLE: begin
            if (v_i) begin
               cap = 1'b1;
               ld  = 1'b1;
               if (cmd_n.cmd_reset) begin
                  ld_data  = '1;
                  ld_count = ctr_width_lp'(reset_ones_p);
                  state_n  = ST_RESET_ONES;
               end else begin
                  ld_data  = hdr_word;
                  ld_count = ctr_width_lp'(hdr_bits_lp);
                  state_n  = ST_HDR;
               end
            end
         end
         ST_RESET_ONES, ST_HDR, ST_PAYLOAD: begin
            en_n   = 1'b1;
            data_n = sh_bit;
            shift  = 1'b1;
            // reset bursts are longer than the shifter; keep feeding ones
            fill   = cmd_reset_r;
            if (sh_done) begin
               ld = 1'b1;
               if (state_r == ST_HDR && len_r != '0) begin
                  ld_data  = shift_width_lp'(payload_r);
                  ld_count = ctr_width_lp'(len_r);
                  state_n  = ST_PAYLOAD;
               end else begin
                  ld_count = ctr_width_lp'(idle_gap_p);
                  inc      = 1'b1;
                  state_n  = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            shift = 1'b1;
            if (sh_done) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r      <= ST_IDLE;
         cmd_reset_r  <= 1'b0;
         len_r        <= '0;
         payload_r    <= '0;
         tag_en_o     <= 1'b0;
         tag_data_o   <= 1'b0;
         sent_count_o <= '0;
      end else begin
         state_r    <= state_n;
         tag_en_o   <= en_n;
         tag_data_o <= data_n;
         if (cap) begin
            cmd_reset_r <= cmd_n.cmd_reset;
            len_r       <= cmd_n.len;
            payload_r   <= cmd_n.payload;
         end
         if (inc) sent_count_o <= sent_count_o + 1'b1;
      end
   end

   assign ready_and_o = (state_r == ST_IDLE);
   assign busy_o      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_bsg_tag_packet_tx.sv
module tb_bsg_tag_packet_tx;
   localparam int LGE = 4, LGW = 4, RONES = 32, GAP = 4;

   logic        clk = 1'b0, reset_n = 1'b0, v = 1'b0;
   logic        cmd_reset = 1'b0, dnr = 1'b0;
   logic [3:0]  node_id = '0, len = '0;
   logic [14:0] payload = '0;
   logic        ready, tdata, ten, busy;
   logic [15:0] sent_count;

   int errors = 0, checks = 0, exp_count = 0;
   bit exp_q[$];
   bit exp2_q[$];
   logic en_a[512], dat_a[512], rdy_a[512], bsy_a[512];

   always #5 clk = ~clk;

   bsg_tag_packet_tx #(.els_p(16), .lg_width_p(LGW), .reset_ones_p(RONES),
                       .idle_gap_p(GAP), .count_width_p(16)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .ready_and_o(ready),
      .cmd_reset_i(cmd_reset), .node_id_i(node_id), .data_not_reset_i(dnr),
      .len_i(len), .payload_i(payload), .tag_data_o(tdata), .tag_en_o(ten),
      .busy_o(busy), .sent_count_o(sent_count));

   // Reference: the serial bit sequence of a command, in wire order
   function automatic void build(input logic r, input logic [3:0] nid, input logic d,
                                 input logic [3:0] l, input logic [14:0] p);
      exp_q.delete();
      if (r) begin
         for (int i = 0; i < RONES; i++) exp_q.push_back(1'b1);
      end else begin
         exp_q.push_back(1'b1);
         for (int i = 0; i < LGE; i++) exp_q.push_back(nid[i]);
         exp_q.push_back(d);
         for (int i = 0; i < LGW; i++) exp_q.push_back(l[i]);
         for (int i = 0; i < int'(l); i++) exp_q.push_back(p[i]);
      end
   endfunction

   // Bit string written in wire order, first bit leftmost
   function automatic void load_lit(input logic [31:0] bits, input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(bits[n-1-i]);
   endfunction

   // Present a command and return at the falling edge after its handshake
   task automatic issue(input logic r, input logic [3:0] nid, input logic d,
                        input logic [3:0] l, input logic [14:0] p);
      bit ok = 0;
      @(negedge clk);
      cmd_reset = r; node_id = nid; dnr = d; len = l; payload = p; v = 1'b1;
      for (int t = 0; t < 200 && !ok; t++) begin
         if (ready === 1'b1) ok = 1;
         else @(negedge clk);
      end
      if (ok) begin
         @(posedge clk);
         @(negedge clk);
      end else begin
         checks++; errors++;
         $display("FAIL handshake_timeout ready=%b required 1", ready);
      end
      v = 1'b0;
      build(r, nid, d, l, p);
   endtask

   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         en_a[i] = ten; dat_a[i] = tdata; rdy_a[i] = ready; bsy_a[i] = busy;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      exp_count = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({ten, tdata, ready, busy} !== 4'b0010 || sent_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_idle[%0d] en,data,ready,busy=%b%b%b%b count=%0d required 0010 count=0",
                     i, ten, tdata, ready, busy, sent_count);
         end
      end
   endtask

   task automatic test_packet();
      int n;
      issue(1'b0, 4'd3, 1'b1, 4'd2, 15'b10);
      load_lit(32'b1110_0101_0001, 12);
      n = exp_q.size();
      capture(n + GAP);
      for (int i = 0; i < n + GAP; i++) begin
         logic ee, ed, er;
         ee = (i < n); ed = (i < n) ? exp_q[i] : 1'b0; er = (i == n + GAP - 1);
         checks++;
         if (en_a[i] !== ee || dat_a[i] !== ed || rdy_a[i] !== er || bsy_a[i] !== !er) begin
            errors++;
            $display("FAIL packet[%0d] en,data,ready,busy=%b%b%b%b required %b%b%b%b",
                     i, en_a[i], dat_a[i], rdy_a[i], bsy_a[i], ee, ed, er, !er);
         end
      end
      exp_count++;
      checks++;
      if (sent_count !== 16'(exp_count)) begin
         errors++; $display("FAIL packet_count got=%0d required %0d", sent_count, exp_count);
      end
   endtask

   task automatic test_zero_len();
      int n;
      issue(1'b0, 4'd15, 1'b0, 4'd0, 15'h7fff);
      load_lit(32'b11111_00000, 10);
      n = exp_q.size();
      capture(n + GAP);
      for (int i = 0; i < n + GAP; i++) begin
         logic ee, ed, er;
         ee = (i < n); ed = (i < n) ? exp_q[i] : 1'b0; er = (i == n + GAP - 1);
         checks++;
         if (en_a[i] !== ee || dat_a[i] !== ed || rdy_a[i] !== er) begin
            errors++;
            $display("FAIL zero_len[%0d] en,data,ready=%b%b%b required %b%b%b",
                     i, en_a[i], dat_a[i], rdy_a[i], ee, ed, er);
         end
      end
      exp_count++;
      checks++;
      if (sent_count !== 16'(exp_count)) begin
         errors++; $display("FAIL zero_len_count got=%0d required %0d", sent_count, exp_count);
      end
   endtask

   task automatic test_master_reset();
      int n;
      issue(1'b1, 4'(($urandom)), 1'($urandom), 4'($urandom), 15'($urandom));
      n = exp_q.size();
      capture(n + GAP);
      for (int i = 0; i < n + GAP; i++) begin
         logic ee, er;
         ee = (i < RONES); er = (i == RONES + GAP - 1);
         checks++;
         if (en_a[i] !== ee || dat_a[i] !== ee || rdy_a[i] !== er) begin
            errors++;
            $display("FAIL master_reset[%0d] en,data,ready=%b%b%b required %b%b%b",
                     i, en_a[i], dat_a[i], rdy_a[i], ee, ee, er);
         end
      end
      exp_count++;
      checks++;
      if (sent_count !== 16'(exp_count)) begin
         errors++; $display("FAIL master_reset_count got=%0d required %0d", sent_count, exp_count);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 16; k++) begin
         int n;
         issue(1'($urandom_range(0, 5) == 0), 4'($urandom), 1'($urandom),
               4'($urandom), 15'($urandom));
         n = exp_q.size();
         capture(n + GAP);
         for (int i = 0; i < n + GAP; i++) begin
            logic ee, ed, er;
            ee = (i < n); ed = (i < n) ? exp_q[i] : 1'b0; er = (i == n + GAP - 1);
            checks++;
            if (en_a[i] !== ee || dat_a[i] !== ed || rdy_a[i] !== er) begin
               errors++;
               $display("FAIL random%0d[%0d] en,data,ready=%b%b%b required %b%b%b",
                        k, i, en_a[i], dat_a[i], rdy_a[i], ee, ed, er);
            end
         end
         exp_count++;
         checks++;
         if (sent_count !== 16'(exp_count)) begin
            errors++; $display("FAIL random%0d_count got=%0d required %0d", k, sent_count, exp_count);
         end
      end
   endtask

   // v_i stays high across two commands; the second one's fields are put
   // on the inputs while the first is still being sent.
   task automatic test_back_to_back();
      int n1, n2, first2;
      build(1'b0, 4'd9, 1'b1, 4'd3, 15'b101);
      exp2_q = exp_q;
      issue(1'b0, 4'd6, 1'b0, 4'd5, 15'b10011);
      n1 = exp_q.size(); n2 = exp2_q.size();
      v = 1'b1; node_id = 4'd9; dnr = 1'b1; len = 4'd3; payload = 15'b101;
      first2 = -1;
      for (int i = 0; i < n1 + GAP + 1 + n2 + GAP; i++) begin
         @(negedge clk);
         en_a[i] = ten; dat_a[i] = tdata;
         if (i == n1 + GAP) v = 1'b0;
         if (i >= n1 && ten === 1'b1 && first2 < 0) first2 = i;
      end
      v = 1'b0;
      checks++;
      if (first2 - n1 !== GAP + 1) begin
         errors++;
         $display("FAIL b2b_low_cycles got=%0d required %0d", first2 - n1, GAP + 1);
      end
      for (int i = 0; i < n1; i++) begin
         checks++;
         if (en_a[i] !== 1'b1 || dat_a[i] !== exp_q[i]) begin
            errors++; $display("FAIL b2b_first[%0d] en,data=%b%b required 1%b", i, en_a[i], dat_a[i], exp_q[i]);
         end
      end
      for (int i = 0; i < n2; i++) begin
         checks++;
         if (en_a[n1+GAP+1+i] !== 1'b1 || dat_a[n1+GAP+1+i] !== exp2_q[i]) begin
            errors++;
            $display("FAIL b2b_second[%0d] en,data=%b%b required 1%b",
                     i, en_a[n1+GAP+1+i], dat_a[n1+GAP+1+i], exp2_q[i]);
         end
      end
      exp_count += 2;
      checks++;
      if (sent_count !== 16'(exp_count)) begin
         errors++; $display("FAIL b2b_count got=%0d required %0d", sent_count, exp_count);
      end
   endtask

   // 20-bit packet (len=10); reset lands where bit 5 (dnr=1) would appear
   task automatic test_mid_reset();
      int n;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      exp_count = 0;
      issue(1'b0, 4'd10, 1'b1, 4'd10, 15'($urandom));
      capture(5);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (en_a[i] !== 1'b1 || dat_a[i] !== exp_q[i]) begin
            errors++; $display("FAIL mid_reset_pre[%0d] en,data=%b%b required 1%b", i, en_a[i], dat_a[i], exp_q[i]);
         end
      end
      reset_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({ten, tdata, ready, busy} !== 4'b0010 || sent_count !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset_abort en,data,ready,busy=%b%b%b%b count=%0d required 0010 count=0",
                  ten, tdata, ready, busy, sent_count);
      end
      reset_n = 1'b1;
      issue(1'b0, 4'd5, 1'b0, 4'd7, 15'($urandom));
      n = exp_q.size();
      capture(n + GAP);
      for (int i = 0; i < n + GAP; i++) begin
         logic ee, ed;
         ee = (i < n); ed = (i < n) ? exp_q[i] : 1'b0;
         checks++;
         if (en_a[i] !== ee || dat_a[i] !== ed) begin
            errors++;
            $display("FAIL mid_reset_after[%0d] en,data=%b%b required %b%b", i, en_a[i], dat_a[i], ee, ed);
         end
      end
      exp_count++;
      checks++;
      if (sent_count !== 16'(exp_count)) begin
         errors++; $display("FAIL mid_reset_count got=%0d required %0d", sent_count, exp_count);
      end
   endtask

   initial begin
      test_reset();
      test_packet();
      test_zero_len();
      test_master_reset();
      test_random();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bsg_tag_packet_tx.md
# bsg_tag_packet_tx

Single-clock bsg_tag packet serializer that drives the tag_clk/tag_en/tag_data inputs of the clock/delay generator's decentralized tag master. It accepts one parallel command per valid/ready handshake and shifts it out bit-serially:
- a tag packet carrying node id, data_not_reset, length and payload, or
- a tag-master reset burst.

A fixed idle gap follows every command. It runs in the tag clock domain and is the sole on-chip source of configuration for the oscillator, downsampler, mux, monitor and divider-counter clients.

## Interface
Parameters:
- els_p, 16: number of tag clients; node id width lg_els = `$clog2(els_p)`.
- lg_width_p, 4: length field width; maximum payload is 2^lg_width_p-1 bits.
- reset_ones_p, 32: number of consecutive 1 bits in a master-reset burst.
- idle_gap_p, 4: number of en-low 0 cycles after every command; must be ≥1.
- count_width_p, 16: width of the sent-command counter.

Ports (clock and reset first):
- clk_i  in  1  tag clock; also forwarded to the tag master as tag_clk_i.
- reset_n_i  in  1  reset, one clock; reset is synchronous and active-low.
- v_i  in  1  command valid.
- ready_and_o  out  1  command accepted on v_i & ready_and_o at a rising edge.
- cmd_reset_i  in  1  1 = master-reset burst (other fields ignored); 0 = packet.
- node_id_i  in  lg_els  destination client id.
- data_not_reset_i  in  1  packet type bit.
- len_i  in  lg_width_p  payload bit count (0 allowed).
- payload_i  in  2^lg_width_p-1  payload; bits above len_i ignored.
- tag_data_o  out  1  serial data, registered.
- tag_en_o  out  1  serial enable, registered.
- busy_o  out  1  high in every state except IDLE.
- sent_count_o  out  count_width_p  number of completed commands, wrapping.

## Operation
- FSM states and transitions:
  - IDLE: ready_and_o=1. On handshake, capture all inputs into a holding register; go to RESET_ONES if cmd_reset_i=1, otherwise HDR.
  - RESET_ONES: emit reset_ones_p cycles of tag_en=1, tag_data=1, then go to GAP.
  - HDR: emit 2+lg_els+lg_width_p bits in this order:
    - start bit 1;
    - node_id, LSB first;
    - data_not_reset;
    - len, LSB first.
    - Then go to PAYLOAD if len>0, otherwise GAP.
  - PAYLOAD: emit payload[0..len-1], LSB first, then go to GAP.
  - GAP: emit idle_gap_p cycles of tag_en=0, tag_data=0, increment sent_count_o by 1 (once per command, on the first GAP cycle), then go to IDLE.
- tag_data_o is 0 whenever tag_en_o is 0.
- Implementation: one shift register plus one bit counter. The counter width covers max(reset_ones_p, 2+lg_els+lg_width_p, 2^lg_width_p-1, idle_gap_p).
- ready_and_o is low in every non-IDLE state, so input changes during a transfer have no effect.
- sent_count_o wraps from all-ones to 0.

## Timing
- Reset: while reset_n_i=0 at an edge, the next state is IDLE. All of the following take the value 0 after that edge: tag_data_o, tag_en_o, busy_o, sent_count_o. ready_and_o takes the value 1.
- Reset mid-command aborts the command immediately; the partial packet is not retransmitted and sent_count_o is not incremented.
- Latency: handshake at edge N; the first serial bit (start bit, or first reset 1) is on tag_data_o after edge N+1.
- Packet duration is 2+lg_els+lg_width_p+len cycles with tag_en_o high, then idle_gap_p cycles low.
- Reset burst duration is reset_ones_p cycles high, then idle_gap_p cycles low.
- ready_and_o rises after the last GAP cycle. The earliest next handshake is at edge N+1+(command bits)+idle_gap_p. No back-to-back commands without a gap.
- Simultaneous reset_n_i=0 and a handshake: reset wins; the command is dropped.

## Structure
- A shared package holds:
  - the packed command struct {cmd_reset, node_id, data_not_reset, len, payload}, parameterized via a `declare_` macro;
  - the FSM state enum;
  - constants for the header bit count.
- Natural sub-module: bsg_tag_packet_tx_shifter. It is a loadable LSB-first shift register with a down-counter and a done flag, reused by the HDR, PAYLOAD and RESET_ONES states.

## Test plan
All scenarios use els_p=16, lg_width_p=4, idle_gap_p=4, reset_ones_p=32.
- Reset then idle: hold reset_n_i=0 for 2 cycles, then release. Required: tag_en_o=0, tag_data_o=0, ready_and_o=1, sent_count_o=0 and busy_o=0 for 10 cycles.
- Packet: node 3, dnr=1, len=2, payload=2'b10. Required: with tag_en_o=1, tag_data_o is 1,1,1,0,0,1,0,1,0,0,0,1 on the 12 cycles after the handshake; then 4 en-low cycles; then sent_count_o=1 and ready_and_o=1.
- Zero-length packet: node 15, dnr=0, len=0. Required: 10 bits 1,1,1,1,1,0,0,0,0,0, then the gap; no PAYLOAD cycles.
- Master reset: cmd_reset_i=1. Required: exactly 32 cycles of en=1 and data=1, then 4 low cycles, then sent_count_o increments.
- Back-to-back: hold v_i=1 with two packets queued. Required: the second start bit appears exactly idle_gap_p+1 cycles after the first packet's last bit.
- Mid-packet reset: assert reset_n_i=0 at bit 5 of a 20-bit packet. Required: outputs are 0 on the next cycle; sent_count_o is unchanged (0); a subsequent packet is emitted intact.
